// File: rtl/mux_16x1_pkg.sv
// Shared constants and FSM state type for the 16:1 round-robin collector.
package mux_16x1_pkg;
  localparam int CH_NUM     = 16;
  localparam int SEL_W      = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/mux_16x1_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or above ptr, wrapping 15 to 0.
module rr_arbiter_16
  import mux_16x1_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_vld,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic [CH_NUM-1:0] gnt_onehot
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      // 4-bit addition wraps the scan naturally past channel 15
      idx = ptr + SEL_W'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (gnt_vld)
      gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_16x1_rr.sv
// Sixteen-channel valid/ready round-robin collector with a one-deep tagged output register.
module mux_16x1_rr
  import mux_16x1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        in_valid,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic [CH_NUM-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_select,
  input  logic                     out_ready
);

  state_t              state;
  logic [SEL_W-1:0]    ptr;
  logic [DATA_W-1:0]   data_p0;
  logic [SEL_W-1:0]    sel_p0;

  logic                gnt_vld;
  logic [SEL_W-1:0]    gnt_idx;
  logic [CH_NUM-1:0]   gnt_onehot;
  logic                load;
  logic                xfer;

  rr_arbiter_16 u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  // rst_n gates in_ready so no requester sees a handshake while reset is held
  assign load     = (state == EMPTY) || out_ready;
  assign in_ready = gnt_onehot & {CH_NUM{load & rst_n}};
  assign xfer     = gnt_vld & load;

  // Stage p0: output register, FSM and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ptr     <= '0;
      data_p0 <= '0;
      sel_p0  <= '0;
    end else if (xfer) begin
      state   <= FULL;
      ptr     <= gnt_idx + SEL_W'(1);
      data_p0 <= in_data[gnt_idx*DATA_W +: DATA_W];
      sel_p0  <= gnt_idx;
    end else if (state == FULL && out_ready) begin
      state   <= EMPTY;
    end
  end

  assign out_valid  = (state == FULL);
  assign out_data   = data_p0;
  assign out_select = sel_p0;

endmodule

// File: tb/tb_mux_16x1_rr.sv
// Scoreboard bench for mux_16x1_rr: directed stimulus pushes expected words, a monitor checks accepted outputs.
module tb_mux_16x1_rr;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [15:0]   in_valid;
  logic [16*DW-1:0] in_data;
  logic [15:0]   in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_select;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  mux_16x1_rr #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_select (out_select),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v);
    in_data[ch*DW +: DW] = v;
  endtask

  task automatic push(input logic [3:0] sel, input logic [DW-1:0] d);
    exp_q.push_back({sel, d});
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: a word is consumed when valid and ready are both high before the edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got sel=%0d data=%0h expected no word", out_select, out_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({out_select, out_data} !== e) begin
          errors++;
          $display("FAIL sb_word: got sel=%0d data=%0h expected sel=%0d data=%0h",
                   out_select, out_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_select", out_select, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single channel 5
    out_ready = 1'b1;
    set_ch(5, 8'hA5);
    in_valid = 16'h0020;
    #1 chk("single_in_ready", in_ready, 16'h0020);
    push(4'd5, 8'hA5);
    tick();
    in_valid = '0;
    #1;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 8'hA5);
    chk("single_out_select", out_select, 5);
    // ptr=6: channels 4 and 7 requesting must pick 7 first
    set_ch(4, 8'h44); set_ch(7, 8'h77);
    in_valid = 16'h0090;
    #1 chk("ptr6_in_ready", in_ready, 16'h0080);
    push(4'd7, 8'h77);
    tick();
    in_valid = 16'h0010;
    #1 chk("ptr8_in_ready", in_ready, 16'h0010);
    push(4'd4, 8'h44);
    tick();
    in_valid = '0;
    tick();
    chk("single_drained", out_valid, 0);

    // Round-robin over all channels
    rst_pulse();
    for (int i = 0; i < 16; i++) set_ch(i, DW'(i));
    in_valid = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      push(4'(k % 16), DW'(k % 16));
      tick();
      chk("rr_no_gap", out_valid, 1);
      chk("rr_select", out_select, k % 16);
    end
    in_valid = '0;
    tick();
    chk("rr_drained", out_valid, 0);

    // Backpressure, ptr=1: channels 3 and 9
    set_ch(3, 8'h33); set_ch(9, 8'h99);
    in_valid = 16'h0208;
    #1 chk("bp_first_grant", in_ready, 16'h0008);
    push(4'd3, 8'h33);
    tick();
    in_valid = 16'h0200;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready_zero", in_ready, 0);
      chk("bp_hold_select", out_select, 3);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h33);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 16'h0200);
    push(4'd9, 8'h99);
    tick();
    chk("bp_ch9_select", out_select, 9);
    in_valid = '0;
    tick();

    // Wrap-around: transfer from 13 leaves ptr=14
    set_ch(13, 8'hD1); set_ch(15, 8'hF1); set_ch(1, 8'h11); set_ch(2, 8'h22);
    in_valid = 16'h2000;
    push(4'd13, 8'hD1);
    tick();
    in_valid = 16'h8002;
    #1 chk("wrap_grant15", in_ready, 16'h8000);
    push(4'd15, 8'hF1);
    tick();
    in_valid = 16'h0002;
    #1 chk("wrap_grant1", in_ready, 16'h0002);
    push(4'd1, 8'h11);
    tick();
    // ptr=2: channels 1 and 2 requesting must pick 2
    in_valid = 16'h0006;
    #1 chk("wrap_ptr2", in_ready, 16'h0004);
    push(4'd2, 8'h22);
    tick();
    in_valid = 16'h0002;
    push(4'd1, 8'h11);
    tick();
    in_valid = '0;
    tick();

    // Drain to empty
    set_ch(0, 8'h3C);
    in_valid = 16'h0001;
    push(4'd0, 8'h3C);
    tick();
    in_valid = '0;
    #1;
    chk("drain_valid_hi", out_valid, 1);
    chk("drain_data_hi", out_data, 8'h3C);
    tick();
    chk("drain_valid_lo", out_valid, 0);
    chk("drain_data_kept", out_data, 8'h3C);
    tick();
    chk("drain_valid_lo2", out_valid, 0);

    // Reset mid-transfer, ptr=1
    for (int i = 0; i < 16; i++) set_ch(i, DW'(8'h50 + i));
    set_ch(0, 8'h5A);
    in_valid = 16'hFFFF;
    push(4'd1, 8'h51);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_select", out_select, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick();
    chk("midrst_held_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 chk("postrst_grant0", in_ready, 16'h0001);
    push(4'd0, 8'h5A);
    tick();
    in_valid = '0;
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
